// File: rtl/acc_pkg.sv
// Shared types for the accumulator DUT and its stimulus driver.
package acc_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  // One queued stimulus transaction; rst_cmd marks an in-band DUT reset request.
  typedef struct packed {
    data_t a;
    data_t b;
    logic  acc;
    logic  en;
    logic  rst_cmd;
  } acc_txn_t;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    DRAIN,
    RSTSEQ
  } drv_state_e;

endpackage

// File: rtl/acc_txn_fifo.sv
// First-word-fall-through FIFO of stimulus transactions.
module acc_txn_fifo
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  acc_txn_t din,
  output acc_txn_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  acc_txn_t          mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_stim_drv.sv
// Stimulus driver: queues transactions, replays them to the accumulator DUT
// with in-band reset commands, and returns each sampled result tagged with an id.
module acc_stim_drv
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned DUT_LAT    = 1,
  parameter int unsigned ID_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  data_t           req_a,
  input  data_t           req_b,
  input  logic            req_acc,
  input  logic            req_en,
  input  logic            req_rst,
  output data_t           dut_a,
  output data_t           dut_b,
  output logic            dut_acc,
  output logic            dut_acc_en_n,
  output logic            dut_rst_n,
  input  data_t           dut_y,
  output logic            rsp_valid,
  output data_t           rsp_y,
  output logic [ID_W-1:0] rsp_id,
  output logic            busy
);

  localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

  drv_state_e                   state_q;
  logic [CNT_W-1:0]             rcnt_q;
  logic [ID_W-1:0]              id_q;
  data_t                        dut_a_q;
  data_t                        dut_b_q;
  logic                         dut_acc_q;
  logic                         dut_acc_en_n_q;
  logic                         dut_rst_n_q;
  logic [DUT_LAT:0]             pvld_q;
  logic [DUT_LAT:0][ID_W-1:0]   pid_q;
  logic                         rsp_valid_q;
  data_t                        rsp_y_q;
  logic [ID_W-1:0]              rsp_id_q;

  acc_txn_t head;
  acc_txn_t req_txn;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push_c;
  logic     pop_c;
  logic     ins_c;
  logic     pipe_busy_c;

  assign req_txn     = '{a: req_a, b: req_b, acc: req_acc, en: req_en, rst_cmd: req_rst};
  assign req_ready   = !fifo_full && (state_q != INIT);
  assign push_c      = req_valid && req_ready;
  assign pipe_busy_c = |pvld_q;
  // A data transaction leaves the FIFO and enters the response pipe this cycle.
  assign ins_c       = (state_q == RUN) && !fifo_empty && !head.rst_cmd;
  // A reset command is consumed only once every outstanding response is collected.
  assign pop_c       = ins_c || ((state_q == DRAIN) && !fifo_empty && !pipe_busy_c);
  assign busy        = !fifo_empty || pipe_busy_c || (state_q != RUN);

  assign dut_a        = dut_a_q;
  assign dut_b        = dut_b_q;
  assign dut_acc      = dut_acc_q;
  assign dut_acc_en_n = dut_acc_en_n_q;
  assign dut_rst_n    = dut_rst_n_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_id       = rsp_id_q;

  acc_txn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (req_txn),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer: reset sequencing, DUT drive registers and id tagging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= INIT;
      rcnt_q         <= CNT_LOAD;
      id_q           <= '0;
      dut_a_q        <= '0;
      dut_b_q        <= '0;
      dut_acc_q      <= 1'b0;
      dut_acc_en_n_q <= 1'b1;
      dut_rst_n_q    <= 1'b0;
    end else begin
      dut_acc_en_n_q <= 1'b1;
      case (state_q)
        INIT, RSTSEQ: begin
          if (rcnt_q == '0) begin
            state_q     <= RUN;
            dut_rst_n_q <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          if (ins_c) begin
            dut_a_q        <= head.a;
            dut_b_q        <= head.b;
            dut_acc_q      <= head.acc;
            dut_acc_en_n_q <= ~head.en;
            id_q           <= id_q + ID_W'(1);
          end else if (!fifo_empty) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pipe_busy_c) begin
            state_q     <= RSTSEQ;
            rcnt_q      <= CNT_LOAD;
            dut_rst_n_q <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Response pipe tracks {valid, id} until the DUT result is ready to sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pvld_q      <= '0;
      pid_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      pvld_q      <= {pvld_q[DUT_LAT-1:0], ins_c};
      pid_q       <= {pid_q[DUT_LAT-1:0], id_q};
      rsp_valid_q <= pvld_q[DUT_LAT];
      if (pvld_q[DUT_LAT]) begin
        rsp_y_q  <= dut_y;
        rsp_id_q <= pid_q[DUT_LAT];
      end
    end
  end

endmodule
